// File: rtl/tick_divider_multi.sv
// Multi-channel programmable tick divider: per-channel one-cycle tick and 50% square wave,
// with shadowed divisor writes that take effect only at the channel's next wrap.
module tick_divider_multi #(
  parameter int          WIDTH       = 20,
  parameter int          NCH         = 4,
  parameter int unsigned DEFAULT_DIV = 625000
) (
  input  logic             fastclock,
  input  logic             reset,
  input  logic [NCH-1:0]   enable,
  input  logic             sync_clear,
  input  logic             load,
  input  logic [3:0]       load_ch,
  input  logic [WIDTH-1:0] load_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq,
  output logic [NCH-1:0]   pending
);

  localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] count_reg, count_next;
      logic [WIDTH-1:0] active_reg, active_next;
      logic [WIDTH-1:0] shadow_reg, shadow_next;
      logic             pending_reg, pending_next;
      logic             tick_reg, tick_next;
      logic             sq_reg, sq_next;
      logic             wrap;
      logic             write;

      // sync_clear outranks the wrap, so it also blocks a pending divisor from applying.
      assign wrap  = enable[gi] && !sync_clear && (count_reg == active_reg);
      assign write = load && (load_ch == 4'(gi));

      always_comb begin
        count_next   = count_reg;
        active_next  = active_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;
        tick_next    = tick_reg;
        sq_next      = sq_reg;

        if (!enable[gi] || sync_clear) begin
          count_next = '0;
          tick_next  = 1'b0;
          sq_next    = 1'b0;
        end else if (wrap) begin
          count_next = '0;
          tick_next  = 1'b1;
          sq_next    = ~sq_reg;
        end else begin
          count_next = count_reg + 1'b1;
          tick_next  = 1'b0;
        end

        // A same-cycle write lands in the shadow only; the wrap uses the value already there.
        if (pending_reg && (wrap || !enable[gi])) begin
          active_next  = shadow_reg;
          pending_next = 1'b0;
        end

        if (write) begin
          shadow_next  = load_div;
          pending_next = 1'b1;
        end
      end

      always_ff @(posedge fastclock or posedge reset) begin
        if (reset) begin
          count_reg   <= '0;
          active_reg  <= DEFAULT_DIV_W;
          shadow_reg  <= DEFAULT_DIV_W;
          pending_reg <= 1'b0;
          tick_reg    <= 1'b0;
          sq_reg      <= 1'b0;
        end else begin
          count_reg   <= count_next;
          active_reg  <= active_next;
          shadow_reg  <= shadow_next;
          pending_reg <= pending_next;
          tick_reg    <= tick_next;
          sq_reg      <= sq_next;
        end
      end

      assign tick[gi]    = tick_reg;
      assign sq[gi]      = sq_reg;
      assign pending[gi] = pending_reg;
    end
  endgenerate

endmodule

// File: tb/tb_tick_divider_multi.sv
// Directed bench for tick_divider_multi with WIDTH=8, NCH=4, DEFAULT_DIV=4.
module tb_tick_divider_multi;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic             fastclock;
  logic             reset;
  logic [NCH-1:0]   enable;
  logic             sync_clear;
  logic             load;
  logic [3:0]       load_ch;
  logic [WIDTH-1:0] load_div;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   sq;
  logic [NCH-1:0]   pending;

  int checks   = 0;
  int failures = 0;

  tick_divider_multi #(.WIDTH(WIDTH), .NCH(NCH), .DEFAULT_DIV(4)) dut (
    .fastclock (fastclock),
    .reset     (reset),
    .enable    (enable),
    .sync_clear(sync_clear),
    .load      (load),
    .load_ch   (load_ch),
    .load_div  (load_div),
    .tick      (tick),
    .sq        (sq),
    .pending   (pending)
  );

  initial fastclock = 1'b0;
  always #5 fastclock = ~fastclock;

  // One rising edge passes; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge fastclock);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = '0; sync_clear = 1'b0; load = 1'b0; load_ch = '0; load_div = '0;
    #1;
    checks++;
    if ({tick, sq, pending} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state tick=%b sq=%b pending=%b required all zero", tick, sq, pending);
    end
    step();
    reset = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic();
    enable = 4'b0001;
    for (int k = 1; k <= 15; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 5 == 0) || sq[0] !== ((k / 5) % 2 == 1)) begin
        failures++;
        $display("FAIL basic_ch0 k=%0d tick=%b sq=%b required tick=%b sq=%b",
                 k, tick[0], sq[0], (k % 5 == 0), ((k / 5) % 2 == 1));
      end
    end
    enable = '0;
    step();
    checks++;
    if (tick[0] !== 1'b0 || sq[0] !== 1'b0) begin
      failures++;
      $display("FAIL disable_clears tick=%b sq=%b required 0 0", tick[0], sq[0]);
    end
    $display("test_basic done");
  endtask

  task automatic test_load_midperiod();
    enable = 4'b0010;
    step(); step();
    load = 1'b1; load_ch = 4'd1; load_div = 8'd9;
    step();
    load = 1'b0;
    checks++;
    if (pending !== 4'b0010) begin
      failures++;
      $display("FAIL load_pending pending=%b required 0010", pending);
    end
    for (int k = 4; k <= 25; k++) begin
      step();
      checks++;
      if (tick[1] !== (k == 5 || k == 15 || k == 25) || pending[1] !== (k < 5)) begin
        failures++;
        $display("FAIL load_apply_ch1 k=%0d tick=%b pending=%b required tick=%b pending=%b",
                 k, tick[1], pending[1], (k == 5 || k == 15 || k == 25), (k < 5));
      end
    end
    enable = '0;
    step();
    $display("test_load_midperiod done");
  endtask

  task automatic test_div_zero_disabled();
    load = 1'b1; load_ch = 4'd2; load_div = 8'd0;
    step();
    load = 1'b0;
    checks++;
    if (pending !== 4'b0100) begin
      failures++;
      $display("FAIL div0_pending pending=%b required 0100", pending);
    end
    step();
    checks++;
    if (pending !== 4'b0000) begin
      failures++;
      $display("FAIL div0_applied pending=%b required 0000", pending);
    end
    enable = 4'b0100;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (tick[2] !== 1'b1 || sq[2] !== (k % 2 == 1)) begin
        failures++;
        $display("FAIL div0_run k=%0d tick=%b sq=%b required tick=1 sq=%b",
                 k, tick[2], sq[2], (k % 2 == 1));
      end
    end
    enable = '0;
    step();
    $display("test_div_zero_disabled done");
  endtask

  task automatic test_back_to_back();
    enable = 4'b0001;
    step();
    load = 1'b1; load_ch = 4'd0; load_div = 8'd7;
    step();
    checks++;
    if (pending[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_pending pending=%b required 1", pending[0]);
    end
    load_div = 8'd2;
    step();
    load = 1'b0;
    for (int k = 4; k <= 14; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 5 || k == 8 || k == 11 || k == 14)) begin
        failures++;
        $display("FAIL b2b_period k=%0d tick=%b required %b",
                 k, tick[0], (k == 5 || k == 8 || k == 11 || k == 14));
      end
    end
    load = 1'b1; load_ch = 4'd15; load_div = 8'd9;
    step();
    load = 1'b0;
    checks++;
    if (pending !== 4'b0000) begin
      failures++;
      $display("FAIL bad_ch_pending pending=%b required 0000", pending);
    end
    for (int k = 15; k <= 17; k++) begin
      if (k > 15) step();
      checks++;
      if (tick[0] !== (k == 17)) begin
        failures++;
        $display("FAIL bad_ch_period k=%0d tick=%b required %b", k, tick[0], (k == 17));
      end
    end
    enable = '0;
    step();
    $display("test_back_to_back done");
  endtask

  task automatic test_sync_clear();
    load = 1'b1; load_ch = 4'd0; load_div = 8'd4;
    step();
    load = 1'b0;
    step();
    enable = 4'b0001;
    for (int k = 1; k <= 6; k++) step();
    enable = 4'b1001;
    step(); step();
    checks++;
    if (sq !== 4'b0001) begin
      failures++;
      $display("FAIL pre_clear_sq sq=%b required 0001", sq);
    end
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    checks++;
    if (tick !== 4'b0000 || sq !== 4'b0000) begin
      failures++;
      $display("FAIL sync_clear tick=%b sq=%b required 0000 0000", tick, sq);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (tick !== ((k == 5) ? 4'b1001 : 4'b0000)) begin
        failures++;
        $display("FAIL clear_align k=%0d tick=%b required %b",
                 k, tick, ((k == 5) ? 4'b1001 : 4'b0000));
      end
    end
    $display("test_sync_clear done");
  endtask

  task automatic test_async_reset();
    load = 1'b1; load_ch = 4'd3; load_div = 8'd9;
    step();
    load = 1'b0;
    checks++;
    if (pending !== 4'b1000 || sq !== 4'b1001) begin
      failures++;
      $display("FAIL pre_reset pending=%b sq=%b required 1000 1001", pending, sq);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tick !== 4'b0000 || sq !== 4'b0000 || pending !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset tick=%b sq=%b pending=%b required all zero", tick, sq, pending);
    end
    step();
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      checks++;
      if (tick !== ((k % 5 == 0) ? 4'b1001 : 4'b0000) || pending !== 4'b0000) begin
        failures++;
        $display("FAIL post_reset_period k=%0d tick=%b pending=%b required %b 0000",
                 k, tick, pending, ((k % 5 == 0) ? 4'b1001 : 4'b0000));
      end
    end
    enable = '0;
    step();
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_load_midperiod();
    test_div_zero_disabled();
    test_back_to_back();
    test_sync_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_divider_multi.md
Name: tick_divider_multi

Overview:
- Parametrised, multi-channel successor to the single fixed-rate slow-tick generator. Each of NCH channels divides fastclock by a runtime-programmable divisor.
- Each channel produces a one-cycle tick pulse and a 50%-duty square wave.
- Divisor updates are glitch-free: they are applied at the channel's next wrap.
- Feeds debouncers, display multiplexers and blink logic that previously each instantiated a fixed divider.

Parameters:
- WIDTH, 20, counter and divisor width in bits.
- NCH, 4, number of independent channels (1..16).
- DEFAULT_DIV, 625000, divisor loaded into every channel at reset; tick period = DIV+1 cycles.

Ports:
- fastclock  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high; clears all state.
- enable  input  NCH  per-channel run enable.
- sync_clear  input  1  synchronous phase restart of all channels.
- load  input  1  single-cycle divisor write strobe.
- load_ch  input  4  target channel index for load.
- load_div  input  WIDTH  new divisor value.
- tick  output  NCH  one-cycle pulse per period, registered.
- sq  output  NCH  square wave toggling at each wrap, registered.
- pending  output  NCH  1 = divisor written but not yet active.

Behaviour:
- Per-channel state: count[WIDTH], active_div[WIDTH], shadow_div[WIDTH], pending bit, tick flop, sq flop.
- Reset (async, any time, including mid-period or mid-load):
  - count=0, active_div=shadow_div=DEFAULT_DIV, pending=0, tick=0, sq=0.
- Enabled channel, each cycle:
  - If count==active_div: count<=0, tick<=1, sq<=~sq (wrap).
  - Else: count<=count+1, tick<=0.
  - Tick period is active_div+1 cycles; tick is high exactly in the cycle where count==0 following a wrap. sq period is 2*(active_div+1).
- Disabled channel (enable[i]=0):
  - count<=0, tick<=0, sq<=0. Divisor state is retained.
  - On re-enable, counting starts from 0. The first tick appears active_div+1 cycles after the first enabled edge.
- div=0: tick held high continuously while enabled; sq toggles every cycle.
- sync_clear=1: every channel count<=0, tick<=0, sq<=0 in that cycle. It has priority over wrap and increment. Pending loads are not applied by sync_clear.
- load handshake:
  - On a load=1 cycle with load_ch<NCH: shadow_div[load_ch]<=load_div and pending[load_ch]<=1.
  - load_ch>=NCH: the write is ignored; no state changes.
  - Apply rule: while pending=1, the next wrap (or any cycle with the channel disabled) copies shadow_div into active_div and clears pending.
  - A wrap in the same cycle as the load uses the old active_div; the new value applies at the following wrap.
  - A second load before apply overwrites shadow_div; only the last value takes effect.
- count never exceeds active_div. Because a divisor changes only at wrap, a smaller new divisor cannot strand count above it.
- Counter arithmetic is unsigned and modulo 2^WIDTH; the increment never overflows because count<=active_div<=2^WIDTH-1.
- Channels are fully independent, except for the shared sync_clear and the shared load port (one write per cycle).

Test Plan:
1. WIDTH=8, DEFAULT_DIV=4, enable=1 on ch0 after reset -> tick[0] high on cycles 5,10,15 after enable. sq[0] toggles at the same cycles (period 10).
2. ch1 running with div=4; load ch1 div=9 at cycle 2 of a period -> pending[1]=1 until the next wrap. That period still ends on the 5-cycle boundary, then ticks every 10 cycles; pending clears at the wrap.
3. Load ch2 div=0 while ch2 disabled -> applied next cycle, pending=0. On enable, tick[2] stays high every cycle and sq[2] toggles each cycle.
4. Two loads to ch0 (7 then 2) within one period -> only div=2 takes effect at the wrap (period 3). Load with load_ch=15 (NCH=4) -> no state change.
5. sync_clear pulsed while ch0 and ch3 run at different phases -> both counts 0. Next ticks occur div+1 cycles later, so equal divisors are phase-aligned; sq=0.
6. reset asserted asynchronously mid-period with a pending load -> tick=sq=pending=0 immediately. After release, period is DEFAULT_DIV+1 (the shadow value is discarded).
